// File: rtl/term_pkg.sv
// Shared geometry, character constants, FSM state type and the
// physical-address helper for the terminal character memory writer.
// Optional feature macro: TERM_MEM_CLR_EN adds the CLR_ALL state.
package term_pkg;

  localparam int COLS      = 40;
  localparam int ROWS      = 24;
  localparam int CHAR_W    = 6;
  localparam int MEM_DEPTH = 1024;

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int POS_W = $clog2(MEM_DEPTH);

  localparam logic [6:0]       ASCII_CR  = 7'h0D;
  localparam logic [5:0]       SPACE6    = 6'h20;
  localparam logic [ROW_W:0]   ROWS_EXT  = (ROW_W+1)'(ROWS);

`ifdef TERM_MEM_CLR_EN
  typedef enum logic [2:0] {IDLE, WRITE, NEWLINE, CLR_LINE, CLR_ALL} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, NEWLINE, CLR_LINE} state_t;
`endif

  // Cell index of (row, col) once the screen has been scrolled by top rows.
  function automatic logic [POS_W-1:0] phys_addr(input logic [ROW_W-1:0] top,
                                                 input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    logic [ROW_W:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= ROWS_EXT) sum = sum - ROWS_EXT;
    phys_addr = POS_W'(sum) * POS_W'(COLS) + POS_W'(col);
  endfunction

endpackage

// File: rtl/term_mem_writer_if.sv
// Character handshake and shift-register bank bus.
// Handshake: a character transfers on a clk edge where char_valid and
// char_ready are both high; char_in must be stable while char_valid is high.
// mem_so is the cell currently at the bank output, mem_si the value that
// enters the bank when shift_en advances it on the same edge.
interface term_mem_writer_if;
  import term_pkg::*;

  logic [6:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic              shift_en;
  logic [CHAR_W-1:0] mem_so;
  logic [CHAR_W-1:0] mem_si;

  modport master (output char_in, char_valid, shift_en, mem_so,
                  input  char_ready, mem_si);

  modport slave  (input  char_in, char_valid, shift_en, mem_so,
                  output char_ready, mem_si);

endinterface

// File: rtl/term_pos_ctr.sv
// Tracks which memory cell is at the bank output and flags when that cell
// is the cursor's cell.
module term_pos_ctr
  import term_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [ROW_W-1:0] top_row,
  input  logic [ROW_W-1:0] cursor_row,
  input  logic [COL_W-1:0] cursor_col,
  output logic [POS_W-1:0] pos,
  output logic             cursor_here
);

  logic [POS_W-1:0] cursor_addr;

  // Position follows the bank: one step per strobe, wrapping at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
    end else if (shift_en) begin
      if (pos == POS_W'(MEM_DEPTH-1)) pos <= '0;
      else                            pos <= pos + 1'b1;
    end
  end

  assign cursor_addr = phys_addr(top_row, cursor_row, cursor_col);
  assign cursor_here = (pos == cursor_addr);

endmodule

// File: rtl/term_mem_writer.sv
// Write and read-back controller for the circulating character memory.
// Recirculates the bank output, substitutes new characters at the cursor
// cell, handles CR, line wrap, scroll via top_row and blank-line fill.
// Optional feature macro: TERM_MEM_CLR_EN (clr_req input, whole-screen clear).
module term_mem_writer
  import term_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  term_mem_writer_if.slave  bus,
`ifdef TERM_MEM_CLR_EN
  input  logic              clr_req,
`endif
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [ROW_W-1:0]  top_row,
  output logic              cursor_here,
  output logic              busy,
  output state_t            state
);

  state_t            state_next;
  logic [CHAR_W-1:0] char_reg;
  logic [POS_W-1:0]  base;
  logic [POS_W-1:0]  cnt;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  line_addr;
  logic [5:0]        fold;
  logic              accept;
  logic              is_cr;
  logic              is_print;
  logic              wr_hit;
  logic              line_hit;
`ifdef TERM_MEM_CLR_EN
  logic              all_hit;
`endif

  term_pos_ctr u_pos (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (bus.shift_en),
    .top_row     (top_row),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .pos         (pos),
    .cursor_here (cursor_here)
  );

  // Lower-case letters are folded to upper case by clearing bit 5.
  always_comb begin
    fold = bus.char_in[5:0];
    if (bus.char_in[6:5] == 2'b11) fold[5] = 1'b0;
  end

  assign is_cr    = (bus.char_in == ASCII_CR);
  assign is_print = (bus.char_in[6:5] != 2'b00);
`ifdef TERM_MEM_CLR_EN
  assign accept   = (state == IDLE) && bus.char_valid && !clr_req;
  assign all_hit  = bus.shift_en && (state == CLR_ALL) && (pos == cnt);
`else
  assign accept   = (state == IDLE) && bus.char_valid;
`endif
  assign line_addr = base + cnt;
  assign wr_hit    = bus.shift_en && (state == WRITE) && cursor_here;
  assign line_hit  = bus.shift_en && (state == CLR_LINE) && (pos == line_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decision: classify at acceptance, leave a state once its write lands.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_cr)         state_next = NEWLINE;
          else if (is_print) state_next = WRITE;
        end
`ifdef TERM_MEM_CLR_EN
        if (clr_req) state_next = CLR_ALL;
`endif
      end
      WRITE: begin
        if (wr_hit) begin
          if (cursor_col == COL_W'(COLS-1)) state_next = NEWLINE;
          else                              state_next = IDLE;
        end
      end
      NEWLINE: begin
        if (cursor_row == ROW_W'(ROWS-1)) state_next = CLR_LINE;
        else                              state_next = IDLE;
      end
      CLR_LINE: begin
        if (line_hit && (cnt == POS_W'(COLS-1))) state_next = IDLE;
      end
`ifdef TERM_MEM_CLR_EN
      CLR_ALL: begin
        if (all_hit && (cnt == POS_W'(COLS*ROWS-1))) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Cursor, scroll offset, held character and clear counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
      base       <= '0;
      cnt        <= '0;
      char_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) char_reg <= fold;
        end
        WRITE: begin
          if (wr_hit && (cursor_col != COL_W'(COLS-1))) cursor_col <= cursor_col + 1'b1;
        end
        NEWLINE: begin
          cursor_col <= '0;
          cnt        <= '0;
          if (cursor_row != ROW_W'(ROWS-1)) begin
            cursor_row <= cursor_row + 1'b1;
          end else begin
            // The old top row becomes the new bottom line and is blanked.
            base <= POS_W'(top_row) * POS_W'(COLS);
            if (top_row == ROW_W'(ROWS-1)) top_row <= '0;
            else                           top_row <= top_row + 1'b1;
          end
        end
        CLR_LINE: begin
          if (line_hit) cnt <= cnt + 1'b1;
        end
`ifdef TERM_MEM_CLR_EN
        CLR_ALL: begin
          if (all_hit) begin
            cnt <= cnt + 1'b1;
            if (cnt == POS_W'(COLS*ROWS-1)) begin
              cursor_col <= '0;
              cursor_row <= '0;
              top_row    <= '0;
            end
          end
        end
`endif
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs: recirculate by default; substitute only on a hit, never during reset.
  always_comb begin
    bus.char_ready = (state == IDLE);
    busy           = (state != IDLE);
    bus.mem_si     = bus.mem_so;
    if (!rst) begin
      if (wr_hit)        bus.mem_si = char_reg;
      else if (line_hit) bus.mem_si = SPACE6;
`ifdef TERM_MEM_CLR_EN
      else if (all_hit)  bus.mem_si = SPACE6;
`endif
    end
  end

endmodule

// File: tb/tb_term_mem_writer.sv
// Bench for term_mem_writer: a behavioural shift-register bank plus a
// screen-level model of where characters and blanks must land.
module tb_term_mem_writer;
  import term_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  term_mem_writer_if bus ();
`ifdef TERM_MEM_CLR_EN
  logic clr_req;
`endif
  logic [COL_W-1:0] cursor_col;
  logic [ROW_W-1:0] cursor_row;
  logic [ROW_W-1:0] top_row;
  logic             cursor_here;
  logic             busy;
  state_t           state;

  term_mem_writer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef TERM_MEM_CLR_EN
    .clr_req     (clr_req),
`endif
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .top_row     (top_row),
    .cursor_here (cursor_here),
    .busy        (busy),
    .state       (state)
  );

  int total = 0;
  int bad   = 0;

  // Memory bank environment: sr is the bank, sp the cell at its output,
  // off the bank cell that the controller calls pos 0 since the last reset.
  logic [CHAR_W-1:0] sr [MEM_DEPTH];
  logic [POS_W-1:0]  sp = '0;
  logic [POS_W-1:0]  off = '0;
  logic              fill = 1'b0;
  int unsigned       seed;

  function automatic logic [5:0] pat(input int i);
    return 6'((i * 37 + int'(seed)) ^ (i >> 4));
  endfunction

  assign bus.mem_so = sr[sp];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < MEM_DEPTH; i++) sr[i] <= pat(i);
    end else if (bus.shift_en) begin
      sr[sp] <= bus.mem_si;
      sp     <= sp + 1'b1;
    end
    if (rst) off <= bus.shift_en ? POS_W'(sp + 1'b1) : sp;
  end

  // Screen-level reference: expected bank image and logical cursor.
  logic [5:0] exp_abs [MEM_DEPTH];
  int m_col, m_row, m_top;

  function automatic void put(input int a, input logic [5:0] v);
    exp_abs[(int'(off) + a) % MEM_DEPTH] = v;
  endfunction

  function automatic int phys(input int r, input int c);
    return ((m_top + r) % ROWS) * COLS + c;
  endfunction

  function automatic void model_newline();
    int b;
    m_col = 0;
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      b = m_top * COLS;
      m_top = (m_top + 1) % ROWS;
      for (int k = 0; k < COLS; k++) put(b + k, 6'h20);
    end
  endfunction

  function automatic void model_char(input logic [6:0] c);
    logic [6:0] v;
    if (c == 7'h0D) begin
      model_newline();
    end else if (c >= 7'h20) begin
      v = (c >= 7'h60) ? c - 7'h20 : c;
      put(phys(m_row, m_col), v[5:0]);
      if (m_col == COLS - 1) model_newline();
      else m_col++;
    end
  endfunction

  function automatic int image_diff();
    int n = 0;
    for (int i = 0; i < MEM_DEPTH; i++) if (sr[i] !== exp_abs[i]) n++;
    return n;
  endfunction

  function automatic logic rnd_se();
    return ($urandom_range(0, 7) != 0);
  endfunction

  task automatic step(input logic se);
    bus.shift_en = se;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.char_valid = 1'b0;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    m_col = 0; m_row = 0; m_top = 0;
  endtask

  // Offer one character, then wait for the controller to finish with it.
  task automatic send_char(input logic [6:0] c, input logic noise, output logic timeout);
    int n;
    n = 0;
    while (!bus.char_ready && n < 4000) begin step(rnd_se()); n++; end
    bus.char_in = c;
    bus.char_valid = 1'b1;
    step(rnd_se());
    bus.char_valid = 1'b0;
    n = 0;
    while (busy && n < 4000) begin
      if (noise) begin
        bus.char_valid = 1'($urandom_range(0, 1));
        bus.char_in = 7'h5A;
      end
      step(rnd_se());
      n++;
    end
    bus.char_valid = 1'b0;
    timeout = busy || !bus.char_ready;
    model_char(c);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.char_ready !== 1'b1 || busy !== 1'b0 || state !== IDLE) begin
      bad++;
      $display("FAIL reset_ctl: ready=%b busy=%b state=%0d, want 1 0 %0d", bus.char_ready, busy, state, IDLE);
    end
    total++;
    if ({cursor_row, cursor_col, top_row} !== '0 || cursor_here !== 1'b1) begin
      bad++;
      $display("FAIL reset_cursor: row=%0d col=%0d top=%0d here=%b, want 0 0 0 1", cursor_row, cursor_col, top_row, cursor_here);
    end
  endtask

  task automatic test_recirc();
    int errs = 0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (bus.mem_si !== bus.mem_so) errs++;
      step(1'b1);
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL recirc_si: %0d cycles with mem_si!=mem_so, want 0", errs); end
    total++;
    if (image_diff() !== 0) begin bad++; $display("FAIL recirc_image: %0d cells changed, want 0", image_diff()); end
    total++;
    if (cursor_here !== 1'b1) begin bad++; $display("FAIL recirc_pos: cursor_here=%b after full turn, want 1", cursor_here); end
  endtask

  task automatic test_char_a();
    logic to;
    send_char(7'h41, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL a_timeout: busy=%b ready=%b, want 0 1", busy, bus.char_ready); end
    total++;
    if (image_diff() !== 0) begin bad++; $display("FAIL a_image: %0d cells wrong, want 0", image_diff()); end
    total++;
    if (cursor_col !== COL_W'(1) || cursor_row !== '0 || bus.char_ready !== 1'b1) begin
      bad++;
      $display("FAIL a_cursor: col=%0d row=%0d ready=%b, want 1 0 1", cursor_col, cursor_row, bus.char_ready);
    end
  endtask

  task automatic test_fold_discard();
    logic to;
    send_char(7'h61, 1'b0, to);
    total++;
    if (to || image_diff() !== 0) begin bad++; $display("FAIL fold_image: timeout=%b wrong cells=%0d, want 0 0", to, image_diff()); end
    send_char(7'h07, 1'b0, to);
    total++;
    if (to || image_diff() !== 0) begin bad++; $display("FAIL discard_image: timeout=%b wrong cells=%0d, want 0 0", to, image_diff()); end
    total++;
    if (cursor_col !== COL_W'(m_col) || cursor_row !== ROW_W'(m_row)) begin
      bad++;
      $display("FAIL discard_cursor: col=%0d row=%0d, want %0d %0d", cursor_col, cursor_row, m_col, m_row);
    end
  endtask

  task automatic test_wrap();
    logic to;
    int tos = 0;
    do_reset();
    for (int i = 0; i < COLS; i++) begin
      send_char(7'($urandom_range(32, 127)), 1'b0, to);
      if (to) tos++;
    end
    total++;
    if (tos !== 0 || image_diff() !== 0) begin bad++; $display("FAIL wrap_image: timeouts=%0d wrong cells=%0d, want 0 0", tos, image_diff()); end
    total++;
    if (cursor_row !== ROW_W'(1) || cursor_col !== '0 || m_row !== 1) begin
      bad++;
      $display("FAIL wrap_cursor: row=%0d col=%0d, want 1 0", cursor_row, cursor_col);
    end
  endtask

  task automatic test_scroll();
    logic to;
    int tos = 0;
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) begin
      send_char(7'h0D, 1'b0, to);
      if (to) tos++;
    end
    total++;
    if (tos !== 0 || cursor_row !== ROW_W'(ROWS-1) || top_row !== '0) begin
      bad++;
      $display("FAIL scroll_pre: timeouts=%0d row=%0d top=%0d, want 0 %0d 0", tos, cursor_row, top_row, ROWS-1);
    end
    send_char(7'h0D, 1'b0, to);
    total++;
    if (to || busy !== 1'b0) begin bad++; $display("FAIL scroll_busy: timeout=%b busy=%b, want 0 0", to, busy); end
    total++;
    if (top_row !== ROW_W'(1) || cursor_row !== ROW_W'(ROWS-1) || cursor_col !== '0) begin
      bad++;
      $display("FAIL scroll_cursor: top=%0d row=%0d col=%0d, want 1 %0d 0", top_row, cursor_row, cursor_col, ROWS-1);
    end
    total++;
    if (image_diff() !== 0) begin bad++; $display("FAIL scroll_image: %0d cells wrong, want 0", image_diff()); end
  endtask

  task automatic test_random();
    logic to;
    logic [6:0] c;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) c = 7'h0D;
      else if (k == 1) begin
        c = 7'($urandom_range(0, 31));
        if (c == 7'h0D) c = 7'h1B;
      end else c = 7'($urandom_range(32, 127));
      send_char(c, 1'b1, to);
      total++;
      if (to || cursor_col !== COL_W'(m_col) || cursor_row !== ROW_W'(m_row) || top_row !== ROW_W'(m_top)) begin
        bad++;
        $display("FAIL random_cursor[%0d] ch=%h: timeout=%b col=%0d row=%0d top=%0d, want 0 %0d %0d %0d",
                 i, c, to, cursor_col, cursor_row, top_row, m_col, m_row, m_top);
      end
    end
    total++;
    if (image_diff() !== 0) begin bad++; $display("FAIL random_image: %0d cells wrong, want 0", image_diff()); end
  endtask

  task automatic test_abort();
    logic [5:0] e;
    do_reset();
    e = exp_abs[int'(off)];
    bus.char_in = {2'b10, ~e[4:0]};
    bus.char_valid = 1'b1;
    step(1'b0);
    bus.char_valid = 1'b0;
    total++;
    if (state !== WRITE || cursor_here !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: state=%0d here=%b, want %0d 1", state, cursor_here, WRITE);
    end
    rst = 1'b1;
    bus.shift_en = 1'b1;
    #1;
    total++;
    if (bus.mem_si !== bus.mem_so) begin bad++; $display("FAIL abort_si: mem_si=%h, want %h", bus.mem_si, bus.mem_so); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.shift_en = 1'b0;
    m_col = 0; m_row = 0; m_top = 0;
    total++;
    if (state !== IDLE || busy !== 1'b0 || image_diff() !== 0) begin
      bad++;
      $display("FAIL abort_post: state=%0d busy=%b wrong cells=%0d, want %0d 0 0", state, busy, image_diff(), IDLE);
    end
  endtask

`ifdef TERM_MEM_CLR_EN
  task automatic test_clr_all();
    int n = 0;
    clr_req = 1'b1;
    bus.char_in = 7'h51;
    bus.char_valid = 1'b1;
    step(rnd_se());
    clr_req = 1'b0;
    bus.char_valid = 1'b0;
    total++;
    if (state !== CLR_ALL) begin bad++; $display("FAIL clr_enter: state=%0d, want %0d", state, CLR_ALL); end
    while (busy && n < 4000) begin step(rnd_se()); n++; end
    for (int a = 0; a < COLS * ROWS; a++) put(a, 6'h20);
    m_col = 0; m_row = 0; m_top = 0;
    total++;
    if (busy !== 1'b0 || image_diff() !== 0) begin bad++; $display("FAIL clr_image: busy=%b wrong cells=%0d, want 0 0", busy, image_diff()); end
    total++;
    if ({cursor_row, cursor_col, top_row} !== '0) begin
      bad++;
      $display("FAIL clr_cursor: row=%0d col=%0d top=%0d, want 0 0 0", cursor_row, cursor_col, top_row);
    end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.shift_en = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_in = '0;
`ifdef TERM_MEM_CLR_EN
    clr_req = 1'b0;
`endif
    seed = $urandom;
    fill = 1'b1;
    step(1'b0);
    fill = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) exp_abs[i] = pat(i);

    test_reset();
    test_recirc();
    test_char_a();
    test_fold_discard();
    test_wrap();
    test_scroll();
    test_random();
    test_abort();
`ifdef TERM_MEM_CLR_EN
    test_clr_all();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/term_mem_writer.md
Name: term_mem_writer

Overview:
- Write and read-back controller for the terminal's circulating character memory: six 1024-bit shift registers, one per character bit, all advancing on a shared strobe.
- Tracks which cell is currently at the memory output. Recirculates that output to the memory input, and substitutes a new character when the cursor cell passes.
- Handles carriage return, line wrap, scrolling via a top-row offset, and blank-line fill.
- Sits between the keyboard/PIA character source and the shift-register bank; display timing reads cursor_here and top_row.

Parameters:
- COLS, 40, visible columns per row
- ROWS, 24, visible rows
- CHAR_W, 6, stored bits per character (one shift register per bit)
- MEM_DEPTH, 1024, shift-register length; must be >= COLS*ROWS

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- shift_en  in  1  memory advance strobe; the shift registers move one cell on the same clk edge
- char_in  in  7  ASCII character from PIA
- char_valid  in  1  char_in valid
- char_ready  out  1  controller accepts a character
- mem_so  in  CHAR_W  current output of the shift-register bank
- mem_si  out  CHAR_W  next input to the shift-register bank (combinational)
- cursor_col  out  $clog2(COLS)  logical cursor column
- cursor_row  out  $clog2(ROWS)  logical cursor row
- top_row  out  $clog2(ROWS)  physical row shown at screen top
- cursor_here  out  1  high when pos equals the cursor's physical address
- busy  out  1  a write or line-clear is pending

Behaviour:
- Reset values (synchronous rst): pos=0, cursor_col=0, cursor_row=0, top_row=0, state=IDLE, char_ready=1, busy=0. Memory contents are not touched.
- pos counter: width $clog2(MEM_DEPTH). Increments on each shift_en and wraps MEM_DEPTH-1 -> 0. Cells COLS*ROWS .. MEM_DEPTH-1 are dead and always recirculate.
- Physical address: phys(row,col) = ((top_row+row) mod ROWS)*COLS + col.
- Default path: mem_si = mem_so.
- IDLE: char_ready=1. On char_valid && char_ready, register the character; char_ready drops on the next cycle.
- Character classification after accept:
  - 0x0D: newline; go to NEWLINE.
  - 0x20-0x5F: store char_in[5:0]; go to WRITE.
  - 0x60-0x7F: fold to upper case (clear bit 5), then store as for 0x20-0x5F.
  - All other codes: discarded; return to IDLE.
- WRITE: on a cycle with shift_en && pos==phys(cursor), drive mem_si = stored char. Then advance the cursor: col+1, or NEWLINE if col==COLS-1.
- The acceptance cycle never writes, even if pos already matches.
- Worst-case write latency is MEM_DEPTH shift_en strobes.
- NEWLINE: col=0.
  - If row < ROWS-1: row+1, return to IDLE.
  - Else: the row stays at ROWS-1, line base = physical address of the old top row; then top_row = (top_row+1) mod ROWS; enter CLR_LINE.
- CLR_LINE: clr_cnt starts at 0. On shift_en && pos==base+clr_cnt, drive mem_si=6'h20 and increment clr_cnt. After writing clr_cnt==COLS-1, return to IDLE.
- busy=1 in WRITE, NEWLINE and CLR_LINE.
- Simultaneous events:
  - char_valid is ignored while busy.
  - shift_en during the acceptance cycle only advances pos.
- rst mid-write or mid-clear: abort with no partial write on the reset cycle; mem_si reverts to recirculation.

Optional Feature:
- Macro: TERM_MEM_CLR_EN.
- Defined: adds input clr_req (1 bit), sampled only in IDLE.
  - A pulse enters CLR_ALL: spaces are written to every visible cell over one full revolution, starting at the first pos==0.
  - Completion: after the write at COLS*ROWS-1. Then cursor=(0,0), top_row=0.
  - clr_req has priority over char_valid in the same cycle.
- Undefined: no clr_req port and no CLR_ALL state; the screen is blanked only by scrolling.

Decomposition:
- Package term_pkg: COLS/ROWS/CHAR_W/MEM_DEPTH defaults, ASCII_CR=7'h0D, SPACE6=6'h20, state enum (IDLE, WRITE, NEWLINE, CLR_LINE, CLR_ALL).
- Sub-module term_pos_ctr: wrapping pos counter plus the phys(row,col) address compare producing cursor_here.

Test Plan:
- Reset, preload mem_so pattern, toggle shift_en 1024 times -> mem_si==mem_so every cycle, pos returns to 0.
- Send 'A' (0x41) at cursor (0,0) -> exactly one write of 6'h01 when pos==0; cursor_col=1; char_ready returns high.
- Send 'a' (0x61) -> stored 6'h01 (folded); send 0x07 -> no write, cursor unchanged.
- 40 printable chars -> last written at pos 39; cursor=(1,0) via wrap.
- Cursor at row 23, send 0x0D -> top_row=1; spaces written at pos 0..39 only; cursor=(23,0); busy low afterwards.
- With TERM_MEM_CLR_EN, clr_req pulse -> 960 cells written 6'h20; cells 960..1023 recirculated; cursor=(0,0), top_row=0.
